// File: rtl/mc_control_unit_p_if.sv
// Control-unit <-> datapath bundle: IR/memory-ready in, control strobes out.
interface mc_control_unit_p_if #(
  parameter int INSTR_W = 16,
  parameter int ALUOP_W = 3
);
  logic [INSTR_W-1:0] instruction;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic [1:0]         mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_src;
  logic               halted;
  logic               fault;
  logic               illegal_op;

  // Control unit side: consumes IR / ready, drives every strobe.
  modport master (
    input  instruction, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, halted, fault, illegal_op
  );

  // Datapath side.
  modport slave (
    output instruction, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, halted, fault, illegal_op
  );
endinterface

// File: rtl/mc_control_unit_p.sv
// Parametrised multicycle Moore control unit with wait states, bounded
// memory-wait timeout (sticky FAULT), HALT and illegal-opcode pulse.
module mc_control_unit_p #(
  parameter int INSTR_W     = 16,
  parameter int OPC_W       = 4,
  parameter int ALUOP_W     = 3,
  parameter int MEM_WAIT_EN = 1,
  parameter int WAIT_MAX    = 15
) (
  input  logic                clk,
  input  logic                rst,
  mc_control_unit_p_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_JMP,
    S_BRZ, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_HALT, S_FAULT
  } state_t;

  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(4'b0000);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(4'b0001);
  localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(4'b0010);
  localparam logic [OPC_W-1:0] OP_BRZ   = OPC_W'(4'b0011);
  localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'b0100);
  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(4'b1000);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(4'b1100);
  localparam logic [OPC_W-1:0] OP_SUBI  = OPC_W'(4'b1101);
  localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'(4'b1110);
  localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'(4'b1111);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);

  // Counter only ever needs to reach WAIT_MAX-1: the next miss is the timeout.
  localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  state_t              r_state, w_state_nxt;
  logic [WCNT_W-1:0]   r_wait;
  logic [OPC_W-1:0]    w_opc;
  logic [ALUOP_W-1:0]  w_func;
  logic                w_ready;
  logic                w_waitst;
  logic                w_timeout;
  logic                w_unused_ok;

  assign w_opc     = bus.instruction[INSTR_W-1 -: OPC_W];
  assign w_func    = bus.instruction[ALUOP_W-1:0];
  assign w_ready   = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign w_waitst  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Fires on the WAIT_MAX-th consecutive not-ready cycle of one access.
  assign w_timeout = (WAIT_MAX != 0) && !w_ready && (r_wait == WAIT_LAST);
  // Address/immediate bits belong to the datapath, not the controller.
  assign w_unused_ok = ^bus.instruction;

  // State register; async reset drops every strobe immediately via IDLE decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Per-access wait counter: cleared whenever the state changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_wait <= '0;
    else if (w_state_nxt != r_state)                r_wait <= '0;
    else if (WAIT_MAX != 0 && w_waitst && !w_ready) r_wait <= r_wait + 1'b1;
  end

  // Next state and Moore control decode (PC/IR strobes gated by ready in FETCH).
  always_comb begin
    w_state_nxt       = r_state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_ADD;
    bus.pc_src        = 2'b00;
    bus.halted        = 1'b0;
    bus.fault         = 1'b0;
    bus.illegal_op    = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = w_ready;
        bus.pc_write  = w_ready;
        if (w_ready)        w_state_nxt = S_DECODE;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b10;
        case (w_opc)
          OP_LOAD:  w_state_nxt = S_MEM_RD;
          OP_STORE: w_state_nxt = S_MEM_WR;
          OP_JUMP:  w_state_nxt = S_JMP;
          OP_BRZ:   w_state_nxt = S_BRZ;
          OP_HALT:  w_state_nxt = S_HALT;
          OP_RTYPE: w_state_nxt = S_EXEC_R;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: w_state_nxt = S_EXEC_I;
          default: begin
            bus.illegal_op = 1'b1;
            w_state_nxt    = S_FETCH;
          end
        endcase
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (w_ready)        w_state_nxt = S_MEM_WB;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        w_state_nxt    = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (w_ready)        w_state_nxt = S_FETCH;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_JMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        w_state_nxt  = S_FETCH;
      end
      S_BRZ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        w_state_nxt       = S_FETCH;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = w_func;
        w_state_nxt   = S_WB_R;
      end
      S_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        w_state_nxt   = S_FETCH;
      end
      S_EXEC_I: begin
        // Opcode low bits map straight onto ADD/SUB/AND/OR; logic ops zero-extend.
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = w_opc[1] ? 2'b11 : 2'b10;
        bus.alu_op    = ALUOP_W'(w_opc[1:0]);
        w_state_nxt   = S_WB_I;
      end
      S_WB_I: begin
        bus.reg_write = 1'b1;
        w_state_nxt   = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault  = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit_p.sv
// Directed bench for mc_control_unit_p: expected control vectors are queued as
// stimulus is driven, then popped and compared when the outputs are sampled.
module tb_mc_control_unit_p;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted, fault, illegal_op;
  } ctl_t;

  typedef enum {E_IDLE, E_FETCH, E_DECODE, E_MEMRD, E_MEMWB, E_MEMWR, E_JMP,
                E_BRZ, E_EXECR, E_WBR, E_EXECI, E_WBI, E_HALT, E_FAULT} tst_t;

  logic clk, rst;
  int   errors = 0;
  int   checks = 0;
  ctl_t  q_exp[$];
  string q_tag[$];

  mc_control_unit_p_if #(.INSTR_W(16), .ALUOP_W(3)) bus();

  mc_control_unit_p #(
    .INSTR_W(16), .OPC_W(4), .ALUOP_W(3), .MEM_WAIT_EN(1), .WAIT_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for a state, the IR and the current mem_ready.
  function automatic ctl_t exp_of(input tst_t st, input logic [15:0] ins, input logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      E_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      E_DECODE: begin
        c.alu_src_b = 2'b10;
        case (ins[15:12])
          4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: c.illegal_op = 1;
          default: ;
        endcase
      end
      E_MEMRD:  begin c.mem_read = 1; c.i_or_d = 1; end
      E_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      E_MEMWR:  begin c.mem_write = 1; c.i_or_d = 1; end
      E_JMP:    begin c.pc_write = 1; c.pc_src = 2'b10; end
      E_BRZ:    begin c.alu_src_a = 1; c.alu_op = 3'd1; c.pc_write_cond = 1; c.pc_src = 2'b01; end
      E_EXECR:  begin c.alu_src_a = 1; c.alu_op = ins[2:0]; end
      E_WBR:    begin c.reg_write = 1; c.reg_dst = 1; end
      E_EXECI:  begin
        c.alu_src_a = 1;
        c.alu_src_b = ins[13] ? 2'b11 : 2'b10;
        c.alu_op    = {1'b0, ins[13:12]};
      end
      E_WBI:    c.reg_write = 1;
      E_HALT:   c.halted = 1;
      E_FAULT:  c.fault = 1;
      default:  ;
    endcase
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.pc_write = bus.pc_write;   c.pc_write_cond = bus.pc_write_cond;
    c.i_or_d = bus.i_or_d;       c.mem_read = bus.mem_read;
    c.mem_write = bus.mem_write; c.ir_write = bus.ir_write;
    c.reg_write = bus.reg_write; c.reg_dst = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg; c.alu_src_a = bus.alu_src_a;
    c.alu_src_b = bus.alu_src_b; c.alu_op = bus.alu_op;
    c.pc_src = bus.pc_src;       c.halted = bus.halted;
    c.fault = bus.fault;         c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  task automatic push(input tst_t st, input string tag);
    q_exp.push_back(exp_of(st, bus.instruction, bus.mem_ready));
    q_tag.push_back(tag);
  endtask

  task automatic pop_check();
    ctl_t  e, o;
    string t;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    o = observe();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, return at posedge+1.
  task automatic step(input tst_t st, input logic [15:0] ins, input logic rdy, input string tag);
    bus.instruction = ins;
    bus.mem_ready   = rdy;
    push(st, tag);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.instruction = '0;
    bus.mem_ready   = 1'b1;
    @(posedge clk); #1;
    step(E_IDLE, 16'h0000, 1, "reset_idle");
    rst = 1'b1;
    step(E_IDLE, 16'h8001, 1, "idle_release");

    // R-type SUB, zero wait
    step(E_FETCH,  16'h8001, 1, "r_fetch");
    step(E_DECODE, 16'h8001, 1, "r_decode");
    step(E_EXECR,  16'h8001, 1, "r_exec_sub");
    step(E_WBR,    16'h8001, 1, "r_wb");

    // LOAD with three wait cycles; ready on the 4th cycle completes normally
    step(E_FETCH,  16'h0000, 1, "ld_fetch");
    step(E_DECODE, 16'h0000, 1, "ld_decode");
    for (int i = 0; i < 3; i++) step(E_MEMRD, 16'h0000, 0, "ld_memrd_wait");
    step(E_MEMRD,  16'h0000, 1, "ld_memrd_ready");
    step(E_MEMWB,  16'h0000, 1, "ld_memwb");

    // ADDI with two wait cycles in FETCH
    step(E_FETCH,  16'hC005, 0, "addi_fetch_wait0");
    step(E_FETCH,  16'hC005, 0, "addi_fetch_wait1");
    step(E_FETCH,  16'hC005, 1, "addi_fetch_ready");
    step(E_DECODE, 16'hC005, 1, "addi_decode");
    step(E_EXECI,  16'hC005, 1, "addi_exec");
    step(E_WBI,    16'hC005, 1, "addi_wb");

    // ORI, zero wait
    step(E_FETCH,  16'hF00F, 1, "ori_fetch");
    step(E_DECODE, 16'hF00F, 1, "ori_decode");
    step(E_EXECI,  16'hF00F, 1, "ori_exec");
    step(E_WBI,    16'hF00F, 1, "ori_wb");

    // STORE, JUMP, BRZ: three-cycle instructions
    step(E_FETCH,  16'h1000, 1, "st_fetch");
    step(E_DECODE, 16'h1000, 1, "st_decode");
    step(E_MEMWR,  16'h1000, 1, "st_memwr");
    step(E_FETCH,  16'h2000, 1, "jmp_fetch");
    step(E_DECODE, 16'h2000, 1, "jmp_decode");
    step(E_JMP,    16'h2000, 1, "jmp");
    step(E_FETCH,  16'h3000, 1, "brz_fetch");
    step(E_DECODE, 16'h3000, 1, "brz_decode");
    step(E_BRZ,    16'h3000, 1, "brz");

    // Illegal opcode 0101: one-cycle pulse, back to FETCH
    step(E_FETCH,  16'h5000, 1, "ill_fetch");
    step(E_DECODE, 16'h5000, 1, "ill_decode");
    step(E_FETCH,  16'h5000, 1, "ill_next_fetch");

    // STORE that never completes: FAULT after 4 wait cycles (WAIT_MAX = 4)
    step(E_DECODE, 16'h1000, 1, "flt_decode");
    for (int i = 0; i < 4; i++) step(E_MEMWR, 16'h1000, 0, "flt_memwr_wait");
    for (int i = 0; i < 3; i++) step(E_FAULT, 16'h1000, 1, "flt_sticky");
    rst = 1'b0;
    #1;
    push(E_IDLE, "flt_async_reset");
    pop_check();
    @(posedge clk); #1;
    rst = 1'b1;
    step(E_IDLE, 16'h1000, 1, "flt_idle_release");

    // Reset asserted in the middle of a MEM_WR cycle
    step(E_FETCH,  16'h1000, 1, "rw_fetch");
    step(E_DECODE, 16'h1000, 1, "rw_decode");
    bus.mem_ready = 1'b0;
    #1;
    push(E_MEMWR, "rw_memwr_before_rst");
    pop_check();
    #1;
    rst = 1'b0;
    #1;
    push(E_IDLE, "rw_memwr_dropped");
    pop_check();
    @(posedge clk); #1;
    step(E_IDLE, 16'h4000, 1, "rw_held_reset");
    rst = 1'b1;
    step(E_IDLE,  16'h4000, 1, "rw_idle_release");
    step(E_FETCH, 16'h4000, 1, "rw_fetch_after_idle");

    // HALT: sticky, no memory traffic
    step(E_DECODE, 16'h4000, 1, "halt_decode");
    for (int i = 0; i < 20; i++) step(E_HALT, 16'h4000, 1, "halt_sticky");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
